// File: rtl/alu_cmp_checker.sv
// alu_cmp_checker: two-stage scoreboard that checks cv32e40p ALU comparison results.
// Define ALU_CMP_CHK_SET_EN to also check the SLTS/SLTU/SLETS/SLETU set operators.
package cv32e40p_pkg;
    typedef enum logic [6:0] {
        ALU_LTS   = 7'b0000000, ALU_LTU   = 7'b0000001, ALU_SLTS  = 7'b0000010, ALU_SLTU  = 7'b0000011,
        ALU_LES   = 7'b0000100, ALU_LEU   = 7'b0000101, ALU_SLETS = 7'b0000110, ALU_SLETU = 7'b0000111,
        ALU_GTS   = 7'b0001000, ALU_GTU   = 7'b0001001, ALU_GES   = 7'b0001010, ALU_GEU   = 7'b0001011,
        ALU_EQ    = 7'b0001100, ALU_NE    = 7'b0001101, ALU_AND   = 7'b0010101, ALU_ADD   = 7'b0011000,
        ALU_SUB   = 7'b0011001, ALU_OR    = 7'b0101110, ALU_XOR   = 7'b0101111
    } alu_opcode_e;
endpackage

module alu_cmp_checker
    import cv32e40p_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              stop_on_fail_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  alu_opcode_e       operator_i,
    input  logic [31:0]       operand_a_i,
    input  logic [31:0]       operand_b_i,
    input  logic [31:0]       result_i,
    input  logic              comparison_result_i,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  skip_cnt_o,
    output logic              mismatch_o,
    output alu_opcode_e       first_fail_op_o,
    output logic [31:0]       first_fail_a_o,
    output logic [31:0]       first_fail_b_o,
    output logic [31:0]       first_fail_res_o,
    output logic              halted_o
);
    typedef enum logic {RUN, HALT} state_e;
    state_e      state;
    logic        s1_v, s1_cmp, s2_v, s2_pass, s2_fail, s2_skip;
    alu_opcode_e s1_op, s2_op;
    logic [31:0] s1_a, s1_b, s1_res, s2_a, s2_b, s2_res, exp_res;
    logic        lts, ltu, eq, chk, exp_cmp, match;

    assign ready_o  = state == RUN;
    assign halted_o = state == HALT;
    assign lts = $signed(s1_a) < $signed(s1_b);
    assign ltu = s1_a < s1_b;
    assign eq  = s1_a == s1_b;

`ifdef ALU_CMP_CHK_SET_EN
    logic set_op;
    always_comb begin
        chk = 1'b1;
        exp_cmp = 1'b0;
        set_op = 1'b0;
        case (s1_op)
            ALU_LTS:   exp_cmp = lts;
            ALU_LTU:   exp_cmp = ltu;
            ALU_GTS:   exp_cmp = !lts && !eq;
            ALU_GTU:   exp_cmp = !ltu && !eq;
            ALU_LES:   exp_cmp = lts || eq;
            ALU_LEU:   exp_cmp = ltu || eq;
            ALU_GES:   exp_cmp = !lts;
            ALU_GEU:   exp_cmp = !ltu;
            ALU_EQ:    exp_cmp = eq;
            ALU_NE:    exp_cmp = !eq;
            ALU_SLTS:  begin exp_cmp = lts; set_op = 1'b1; end
            ALU_SLTU:  begin exp_cmp = ltu; set_op = 1'b1; end
            ALU_SLETS: begin exp_cmp = lts || eq; set_op = 1'b1; end
            ALU_SLETU: begin exp_cmp = ltu || eq; set_op = 1'b1; end
            default:   chk = 1'b0;
        endcase
    end
    assign exp_res = set_op ? {31'b0, exp_cmp} : {32{exp_cmp}};
`else
    always_comb begin
        chk = 1'b1;
        exp_cmp = 1'b0;
        case (s1_op)
            ALU_LTS: exp_cmp = lts;
            ALU_LTU: exp_cmp = ltu;
            ALU_GTS: exp_cmp = !lts && !eq;
            ALU_GTU: exp_cmp = !ltu && !eq;
            ALU_LES: exp_cmp = lts || eq;
            ALU_LEU: exp_cmp = ltu || eq;
            ALU_GES: exp_cmp = !lts;
            ALU_GEU: exp_cmp = !ltu;
            ALU_EQ:  exp_cmp = eq;
            ALU_NE:  exp_cmp = !eq;
            default: chk = 1'b0;
        endcase
    end
    assign exp_res = {32{exp_cmp}};
`endif

    assign match = s1_res == exp_res && s1_cmp == exp_cmp;

    // Payload registers need no reset: they are only consumed under the valid bits.
    always_ff @(posedge clk) begin
        if (valid_i && ready_o) begin
            s1_op  <= operator_i;
            s1_a   <= operand_a_i;
            s1_b   <= operand_b_i;
            s1_res <= result_i;
            s1_cmp <= comparison_result_i;
        end
        s2_op   <= s1_op;
        s2_a    <= s1_a;
        s2_b    <= s1_b;
        s2_res  <= s1_res;
        s2_pass <= chk && match;
        s2_fail <= chk && !match;
        s2_skip <= !chk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            s1_v             <= 1'b0;
            s2_v             <= 1'b0;
            pass_cnt_o       <= '0;
            fail_cnt_o       <= '0;
            skip_cnt_o       <= '0;
            mismatch_o       <= 1'b0;
            first_fail_op_o  <= ALU_LTS;
            first_fail_a_o   <= '0;
            first_fail_b_o   <= '0;
            first_fail_res_o <= '0;
        end else if (clear_i) begin
            state            <= RUN;
            s1_v             <= 1'b0;
            s2_v             <= 1'b0;
            pass_cnt_o       <= '0;
            fail_cnt_o       <= '0;
            skip_cnt_o       <= '0;
            mismatch_o       <= 1'b0;
            first_fail_op_o  <= ALU_LTS;
            first_fail_a_o   <= '0;
            first_fail_b_o   <= '0;
            first_fail_res_o <= '0;
        end else begin
            s1_v <= valid_i && ready_o;
            s2_v <= s1_v;
            if (s2_v && s2_pass && ~&pass_cnt_o) pass_cnt_o <= pass_cnt_o + CNT_W'(1);
            if (s2_v && s2_skip && ~&skip_cnt_o) skip_cnt_o <= skip_cnt_o + CNT_W'(1);
            if (s2_v && s2_fail) begin
                if (~&fail_cnt_o) fail_cnt_o <= fail_cnt_o + CNT_W'(1);
                if (!mismatch_o) begin
                    first_fail_op_o  <= s2_op;
                    first_fail_a_o   <= s2_a;
                    first_fail_b_o   <= s2_b;
                    first_fail_res_o <= s2_res;
                end
                mismatch_o <= 1'b1;
                if (stop_on_fail_i) state <= HALT;
            end
        end
    end
endmodule
